// File: rtl/data_ram.sv
// Word-organised data memory for the RV32I execute stage: byte-lane stores go
// through a one-entry posted write buffer, and loads see it via forwarding.
`timescale 1ns/1ps

module data_ram #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_we,
    input  logic [3:0]  ram_sel,
    input  logic [31:0] ram_wraddr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_rdata,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [15:0] wr_count
);

    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    // ------------------------------------------------------------------
    // Address decode and store legality
    // ------------------------------------------------------------------
    logic [31:0]       offset;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              sel_ok;
    logic              store_ok;

    // Addresses below BASE_ADDR wrap to a huge offset and land out of range.
    assign offset   = ram_wraddr - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign idx      = offset[ADDR_W+1:2];

    always_comb begin
        sel_ok = 1'b0;
        case (ram_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_ok = 1'b1;
            default:                   sel_ok = 1'b0;
        endcase
    end

    assign store_ok = ram_we && in_range && sel_ok;

    // ------------------------------------------------------------------
    // Storage and posted write buffer
    // ------------------------------------------------------------------
    logic [31:0]       mem [DEPTH];
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_idx;
    logic [3:0]        pend_sel;
    logic [31:0]       pend_data;

    // NOTE: the array has no reset; only control state is cleared, which keeps
    // the storage mappable onto block RAM and leaves contents across reset.
    always_ff @(posedge clk) begin
        if (rst && pend_valid) begin
            for (int n = 0; n < 4; n++) begin
                if (pend_sel[n]) begin
                    mem[pend_idx][8*n +: 8] <= pend_data[8*n +: 8];
                end
            end
        end
    end

    // Commit of the old entry and capture of a new one share the same edge,
    // so back-to-back stores never stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_sel   <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= store_ok;
            if (store_ok) begin
                pend_idx  <= idx;
                pend_sel  <= ram_sel;
                pend_data <= ram_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error capture and commit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            err      <= 1'b0;
            err_addr <= '0;
            wr_count <= '0;
        end else begin
            if (ram_we && !store_ok) begin
                err <= 1'b1;
                if (!err) begin
                    err_addr <= ram_wraddr;
                end
            end
            if (pend_valid && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read: array word first, pending overlay on top
    // ------------------------------------------------------------------
    logic [31:0] merged;

    always_comb begin
        merged = mem[idx];
        if (pend_valid && pend_idx == idx) begin
            for (int n = 0; n < 4; n++) begin
                if (pend_sel[n]) begin
                    merged[8*n +: 8] = pend_data[8*n +: 8];
                end
            end
        end
        ram_rdata = (rst && in_range) ? merged : 32'h0;
    end

endmodule

// File: tb/tb_data_ram.sv
// Randomised scoreboard bench for data_ram: an architectural memory model
// predicts every cycle's outputs and a negedge monitor compares them.
`timescale 1ns/1ps

module tb_data_ram;

    localparam int unsigned DEPTH     = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wraddr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] wr_count;

    data_ram #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_we     (ram_we),
        .ram_sel    (ram_sel),
        .ram_wraddr (ram_wraddr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .err        (err),
        .err_addr   (err_addr),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_rd;
        bit          chk_st;
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] err_addr;
        logic [15:0] wr_count;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Architectural model: a store lands in m_mem at its capture edge; the
    // undo record lets a reset on the following edge discard it.
    logic [31:0] m_mem [DEPTH];
    bit          undo_v = 0;
    int unsigned undo_idx;
    logic [31:0] undo_word;
    bit          m_err = 0;
    logic [31:0] m_err_addr = '0;
    int unsigned m_cnt = 0;

    function automatic bit legal_sel(input logic [3:0] s);
        return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                         4'b0011, 4'b1100, 4'b1111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the model.
    task automatic cyc(input logic r, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input string name, input bit chk_rd, input bit chk_st,
                       input bit use_want, input logic [31:0] want);
        exp_t        e;
        logic [31:0] off;
        bit          inr;
        int unsigned wi;
        logic [31:0] w;
        @(posedge clk);
        #1;
        rst = r; ram_we = we; ram_sel = sel; ram_wraddr = addr; ram_wdata = wd;
        off = addr - BASE_ADDR;
        inr = off < DEPTH * 4;
        wi  = (off / 4) % DEPTH;
        e.chk_rd   = chk_rd;
        e.chk_st   = chk_st;
        e.name     = name;
        e.rdata    = use_want ? want : ((r && inr) ? m_mem[wi] : 32'h0);
        e.err      = m_err;
        e.err_addr = m_err_addr;
        e.wr_count = 16'(m_cnt);
        sb_q.push_back(e);
        if (!r) begin
            if (undo_v) m_mem[undo_idx] = undo_word;
            undo_v = 0; m_err = 0; m_err_addr = '0; m_cnt = 0;
        end else begin
            if (undo_v && m_cnt < 65535) m_cnt++;
            undo_v = 0;
            if (we && inr && legal_sel(sel)) begin
                undo_v = 1; undo_idx = wi; undo_word = m_mem[wi];
                w = m_mem[wi];
                for (int n = 0; n < 4; n++) if (sel[n]) w[8*n +: 8] = wd[8*n +: 8];
                m_mem[wi] = w;
            end else if (we) begin
                if (!m_err) m_err_addr = addr;
                m_err = 1;
            end
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input string n);
        cyc(1'b1, 1'b1, s, a, d, n, 1'b1, 1'b1, 1'b0, '0);
    endtask
    task automatic rd(input logic [31:0] a, input string n);
        cyc(1'b1, 1'b0, 4'h0, a, 32'h0, n, 1'b1, 1'b1, 1'b0, '0);
    endtask
    task automatic rd_want(input logic [31:0] a, input logic [31:0] want, input string n);
        cyc(1'b1, 1'b0, 4'h0, a, 32'h0, n, 1'b1, 1'b1, 1'b1, want);
    endtask

    // Monitor: every cycle the DUT presents a read result and its status.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk_rd) check({e.name, ".rdata"}, ram_rdata, e.rdata);
                if (e.chk_st) begin
                    check({e.name, ".err"},      {31'h0, err}, {31'h0, e.err});
                    check({e.name, ".err_addr"}, err_addr,     e.err_addr);
                    check({e.name, ".wr_count"}, {16'h0, wr_count}, {16'h0, e.wr_count});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  legal_list [7];
        logic [3:0]  s;
        logic [31:0] a;
        legal_list = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        rst = 1'b0; ram_we = 1'b0; ram_sel = '0; ram_wraddr = '0; ram_wdata = '0;

        // First reset cycle: nothing defined yet; second: reset state visible.
        cyc(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "pre_reset", 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "reset", 1'b1, 1'b1, 1'b0, '0);

        // Give every word a known value so the model covers all reads.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom(), "fill", 1'b0, 1'b1, 1'b0, '0);
        rd(32'h0, "fill_idle");
        cyc(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "reset2a", 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "reset2b", 1'b1, 1'b1, 1'b0, '0);

        // Word store, forwarding then array read.
        st(32'h10, 4'hF, 32'hDEADBEEF, "sw_10");
        rd_want(32'h10, 32'hDEADBEEF, "fwd_10");
        rd_want(32'h10, 32'hDEADBEEF, "arr_10");
        rd(32'h10, "cnt_after_sw");

        // Byte then half store into the same word.
        st(32'h12, 4'b0100, 32'h5A5A5A5A, "sb_12");
        rd_want(32'h10, 32'hDE5ABEEF, "rd_sb");
        st(32'h10, 4'b0011, 32'h12341234, "sh_10");
        rd_want(32'h10, 32'hDE5A1234, "rd_sh");

        // Back-to-back stores, and same-word commit plus capture.
        st(32'h20, 4'hF, 32'h1, "sw_20");
        st(32'h24, 4'hF, 32'h2, "sw_24");
        rd_want(32'h20, 32'h00000001, "rd_20");
        rd_want(32'h24, 32'h00000002, "rd_24");
        st(32'h40, 4'hF, 32'h11223344, "sw_40");
        st(32'h40, 4'b0001, 32'hAAAAAAAA, "sb_40");
        st(32'h43, 4'b1000, 32'hBBBBBBBB, "sb_43");
        rd_want(32'h40, 32'hBB2233AA, "rd_40");

        // Illegal stores: zero mask, bad mask, out of range.
        st(32'h13, 4'b0000, 32'hFFFFFFFF, "bad_zero");
        rd_want(32'h10, 32'hDE5A1234, "rd_after_bad");
        st(32'h10, 4'b0101, 32'hFFFFFFFF, "bad_mask");
        st(32'h10000, 4'hF, 32'hFFFFFFFF, "bad_range");
        rd_want(32'h10000, 32'h0, "rd_oor");
        rd_want(32'h10, 32'hDE5A1234, "rd_after_bads");

        // A store followed by reset is discarded, as is a store under reset.
        st(32'h30, 4'hF, 32'hCAFEF00D, "sw_30");
        cyc(1'b0, 1'b1, 4'hF, 32'h34, 32'h55555555, "reset_mid", 1'b1, 1'b1, 1'b0, '0);
        rd(32'h30, "rd_30_after_reset");
        rd(32'h34, "rd_34_after_reset");

        // Random mix of loads, stores (legal and not) and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            s = ($urandom_range(0, 1) == 1) ? legal_list[$urandom_range(0, 6)]
                                            : 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 32'h1200));
            cyc(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), s, a, $urandom(),
                "rand", 1'b1, 1'b1, 1'b0, '0);
        end

        // Commit counter saturation.
        for (int i = 0; i < 65540; i++)
            cyc(1'b1, 1'b1, 4'hF, 32'($urandom_range(0, DEPTH - 1) * 4), $urandom(),
                "sat", 1'b1, 1'b1, 1'b0, '0);
        rd(32'h0, "sat_end_a");
        rd(32'h4, "sat_end_b");
        @(posedge clk);
        #1;
        ram_we = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("wr_count_saturated", {16'h0, wr_count}, 32'h0000FFFF);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Word-organised data memory that responds to the execute stage's load/store RAM interface.
- Accepts byte-lane stores through a one-entry posted write buffer and serves combinational reads with store-to-load forwarding, so a load sees the previous cycle's store.
- Flags illegal stores: out-of-range address, unsupported lane mask, or zero mask with write enable.
- Sits directly beside the execute stage in the RV32I core.

Parameters:
- DEPTH, 1024, number of 32-bit words in storage.
- ADDR_W, 10, word-index width, equal to log2(DEPTH).
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be DEPTH*4-aligned.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- ram_we  input  1  store request, 1 = write.
- ram_sel  input  4  byte-lane enables; bit n selects byte n, i.e. bits [8n+7:8n].
- ram_wraddr  input  32  byte address for both load and store.
- ram_wdata  input  32  store data, already lane-replicated by the initiator.
- ram_rdata  output  32  combinational read word at ram_wraddr.
- err  output  1  sticky illegal-store flag.
- err_addr  output  32  ram_wraddr of the first illegal store since reset.
- wr_count  output  16  number of committed stores, saturating.

Behaviour:
- Decode:
  - offset = ram_wraddr - BASE_ADDR.
  - in_range = offset < DEPTH*4.
  - idx = offset[ADDR_W+1:2]; byte address bits [1:0] are ignored for indexing.
- Legal lane masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Store is legal when ram_we=1, in_range=1 and ram_sel is a legal mask.
- Pending buffer registers: pend_valid, pend_idx, pend_sel, pend_data.
- Every rising edge with rst=1:
  - If pend_valid: write pend_data lanes selected by pend_sel into mem[pend_idx]; unselected bytes are unchanged. wr_count increments, saturating at 16'hFFFF.
  - If the current store is legal: capture idx, ram_sel and ram_wdata into the buffer and set pend_valid=1. Otherwise pend_valid=0.
  - The two actions above happen on the same edge when both apply; back-to-back stores sustain one per cycle with no stall.
  - If ram_we=1 and the store is illegal: set err=1. If err was 0 before this edge, load err_addr<=ram_wraddr. No memory or buffer change from that store.
  - ram_we=0: ram_sel and ram_wdata are ignored; no error is raised.
- Read path (combinational, rst=1):
  - Start from base = mem[idx].
  - If pend_valid and pend_idx==idx: replace each byte n where pend_sel[n]=1 with pend_data byte n.
  - ram_rdata = the merged word if in_range, else 32'h0.
  - Read is independent of ram_we; during a store cycle, ram_rdata shows the pre-store merged contents.
- Store latency: a store's data is visible on ram_rdata in the cycle after its capture edge through forwarding. It is in the array one cycle later.
- Reset (rst=0 at an edge):
  - pend_valid<=0; any pending store is discarded, not committed.
  - err<=0, err_addr<=0, wr_count<=0.
  - Memory contents are not cleared.
  - ram_rdata=32'h0 while rst=0.
- Reset mid-store: a store presented in the same cycle as reset is dropped.
- Lane merge order is fixed: array first, pending overlay second. A commit and a new capture to the same idx therefore yield the newest data.
- Address wrap: ram_wraddr below BASE_ADDR underflows offset to a large value, so in_range=0. These are reads of 0 and illegal stores.

Test Plan:
- Reset with rst=0 for 2 cycles, then SW 32'hDEADBEEF to addr 0x10 with sel 1111 -> next cycle ram_rdata=DEADBEEF at 0x10 via forwarding; the cycle after, still DEADBEEF from the array; wr_count=1.
- After the previous store, SB with wdata 32'h5A5A5A5A, sel 0100 at 0x12 -> read 0x10 returns DE5ABEEF. Then SH with 32'h12341234, sel 0011 at 0x10 -> read 0x10 returns DE5A1234.
- Back-to-back SW to 0x20 (32'h1) and 0x24 (32'h2) in consecutive cycles, then loads of both -> 00000001 and 00000002; wr_count increases by 2.
- Store with ram_we=1, sel 0000 at 0x13 -> err=1, err_addr=0x13, memory unchanged. A later SW to 0x10000 (out of range, DEPTH=1024) -> err stays 1, err_addr stays 0x13. A read at 0x10000 returns 0.
- SW 32'hCAFEF00D to 0x30, then assert rst=0 on the next edge -> after release, read of 0x30 returns the old contents; err=0; wr_count=0.
- 65540 consecutive legal stores -> wr_count saturates at 16'hFFFF and does not wrap.
